// File: rtl/hazard_detection_unit.sv
// Hazard detection unit for a 5-stage pipeline with branches resolved in ID.
//
// Detects load-use and branch-operand hazards against the instructions in EX
// and MEM, stalls the front end (PC and IF/ID held, bubble into ID/EX),
// flushes IF/ID on a taken branch, and freezes the pipeline on a debug halt.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_rs_ID, i_rt_ID               source registers of the ID instruction
//   i_use_rs_ID, i_use_rt_ID       ID instruction actually reads rs / rt
//   i_branch_ID, i_branch_taken    ID holds a branch / it resolved taken
//   i_reg_sel_EX, i_flg_reg_wr_en_EX, i_flg_mem_rd_EX   EX destination info
//   i_reg_sel_MEM, i_flg_mem_rd_MEM                     MEM destination info
//   i_halt                         debug freeze request
//   o_pc_wr_en, o_IF_ID_wr_en      front-end write enables
//   o_ID_EX_bubble, o_IF_ID_flush  insert NOP into ID/EX, clear IF/ID
//   o_stall_cycles                 saturating count of bubble cycles
module hazard_detection_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_rs_ID,
  input  logic [4:0]  i_rt_ID,
  input  logic        i_use_rs_ID,
  input  logic        i_use_rt_ID,
  input  logic        i_branch_ID,
  input  logic        i_branch_taken,
  input  logic [4:0]  i_reg_sel_EX,
  input  logic        i_flg_reg_wr_en_EX,
  input  logic        i_flg_mem_rd_EX,
  input  logic [4:0]  i_reg_sel_MEM,
  input  logic        i_flg_mem_rd_MEM,
  input  logic        i_halt,
  output logic        o_pc_wr_en,
  output logic        o_IF_ID_wr_en,
  output logic        o_ID_EX_bubble,
  output logic        o_IF_ID_flush,
  output logic [15:0] o_stall_cycles
);

  typedef enum logic [1:0] {StRun, StStall, StHalt} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic match_ex, match_mem;
  logic hz_any, hz_two;

  // r0 is hardwired zero, so a write to it never creates a dependency.
  always_comb begin
    match_ex  = (i_reg_sel_EX != 5'd0) &&
                ((i_use_rs_ID && (i_rs_ID == i_reg_sel_EX)) ||
                 (i_use_rt_ID && (i_rt_ID == i_reg_sel_EX)));
    match_mem = (i_reg_sel_MEM != 5'd0) &&
                ((i_use_rs_ID && (i_rs_ID == i_reg_sel_MEM)) ||
                 (i_use_rt_ID && (i_rt_ID == i_reg_sel_MEM)));
  end

  // A load in EX feeding a branch needs two stalls; every other hazard needs one.
  always_comb begin
    hz_two = i_branch_ID & i_flg_mem_rd_EX & match_ex;
    hz_any = (i_flg_mem_rd_EX & match_ex) |
             (i_branch_ID & i_flg_reg_wr_en_EX & ~i_flg_mem_rd_EX & match_ex) |
             (i_branch_ID & i_flg_mem_rd_MEM & match_mem);
  end

  // Outputs are combinational so a hazard stalls in the cycle it is seen.
  always_comb begin
    o_pc_wr_en     = 1'b1;
    o_IF_ID_wr_en  = 1'b1;
    o_ID_EX_bubble = 1'b0;
    o_IF_ID_flush  = 1'b0;
    if (!i_rst_n) begin
      o_pc_wr_en     = 1'b0;
      o_IF_ID_wr_en  = 1'b0;
      o_ID_EX_bubble = 1'b1;
    end else if (i_halt || (state_q == StHalt)) begin
      o_pc_wr_en    = 1'b0;
      o_IF_ID_wr_en = 1'b0;
    end else if ((state_q == StStall) || hz_any) begin
      // Branch outcome is not trusted while its operands are still in flight.
      o_pc_wr_en     = 1'b0;
      o_IF_ID_wr_en  = 1'b0;
      o_ID_EX_bubble = 1'b1;
    end else begin
      o_IF_ID_flush = i_branch_taken & i_branch_ID;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (i_halt) begin
          state_d = StHalt;
        end else if (hz_two) begin
          cnt_d   = 2'd1;
          state_d = StStall;
        end
      end
      StStall: begin
        if (i_halt) begin
          state_d = StHalt;
        end else if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StHalt: begin
        // cnt stays frozen so the interrupted stall resumes where it left off.
        if (!i_halt) begin
          state_d = (cnt_q != 2'd0) ? StStall : StRun;
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (o_ID_EX_bubble && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= StRun;
      cnt_q          <= 2'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [4:0]  i_rs_ID, i_rt_ID;
  logic        i_use_rs_ID, i_use_rt_ID;
  logic        i_branch_ID, i_branch_taken;
  logic [4:0]  i_reg_sel_EX;
  logic        i_flg_reg_wr_en_EX, i_flg_mem_rd_EX;
  logic [4:0]  i_reg_sel_MEM;
  logic        i_flg_mem_rd_MEM;
  logic        i_halt;
  logic        o_pc_wr_en, o_IF_ID_wr_en, o_ID_EX_bubble, o_IF_ID_flush;
  logic [15:0] o_stall_cycles;

  hazard_detection_unit dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_rs_ID            (i_rs_ID),
    .i_rt_ID            (i_rt_ID),
    .i_use_rs_ID        (i_use_rs_ID),
    .i_use_rt_ID        (i_use_rt_ID),
    .i_branch_ID        (i_branch_ID),
    .i_branch_taken     (i_branch_taken),
    .i_reg_sel_EX       (i_reg_sel_EX),
    .i_flg_reg_wr_en_EX (i_flg_reg_wr_en_EX),
    .i_flg_mem_rd_EX    (i_flg_mem_rd_EX),
    .i_reg_sel_MEM      (i_reg_sel_MEM),
    .i_flg_mem_rd_MEM   (i_flg_mem_rd_MEM),
    .i_halt             (i_halt),
    .o_pc_wr_en         (o_pc_wr_en),
    .o_IF_ID_wr_en      (o_IF_ID_wr_en),
    .o_ID_EX_bubble     (o_ID_EX_bubble),
    .o_IF_ID_flush      (o_IF_ID_flush),
    .o_stall_cycles     (o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference model: pending extra stall cycles, frozen flag, bubble count.
  int m_extra  = 0;
  bit m_halted = 0;
  int m_count  = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && ((i_use_rs_ID && i_rs_ID == r) || (i_use_rt_ID && i_rt_ID == r));
  endfunction

  // Stall length demanded by the current inputs, taking the worst applicable rule.
  function automatic int hazard_len();
    int l = 0;
    bit ex_hit  = reads(i_reg_sel_EX);
    bit mem_hit = reads(i_reg_sel_MEM);
    if (i_flg_mem_rd_EX && ex_hit) l = i_branch_ID ? 2 : 1;
    if (i_branch_ID && i_flg_reg_wr_en_EX && !i_flg_mem_rd_EX && ex_hit && l < 1) l = 1;
    if (i_branch_ID && i_flg_mem_rd_MEM && mem_hit && l < 1) l = 1;
    return l;
  endfunction

  task automatic clear_inputs();
    i_rs_ID = 0; i_rt_ID = 0; i_use_rs_ID = 0; i_use_rt_ID = 0;
    i_branch_ID = 0; i_branch_taken = 0;
    i_reg_sel_EX = 0; i_flg_reg_wr_en_EX = 0; i_flg_mem_rd_EX = 0;
    i_reg_sel_MEM = 0; i_flg_mem_rd_MEM = 0; i_halt = 0;
  endtask

  // Called with clk low and inputs already applied; returns at the next falling edge.
  task automatic step(input string tag, input bit chk);
    int len;
    logic [3:0] e;  // {pc_wr_en, IF_ID_wr_en, bubble, flush}
    #2;
    len = hazard_len();
    if (!i_rst_n) begin
      m_count = 0; m_extra = 0; m_halted = 0;
      e = 4'b0010;
    end else if (i_halt || m_halted) begin
      e = 4'b0000;
    end else if (m_extra > 0 || len > 0) begin
      e = 4'b0010;
    end else begin
      e = {3'b110, i_branch_taken & i_branch_ID};
    end
    if (chk) begin
      check({tag, ".ctl"}, {12'd0, o_pc_wr_en, o_IF_ID_wr_en, o_ID_EX_bubble, o_IF_ID_flush},
            {12'd0, e});
      check({tag, ".cnt"}, o_stall_cycles, m_count[15:0]);
    end
    @(posedge i_clk);
    if (i_rst_n) begin
      if (e[1] && m_count < 65535) m_count++;
      if (i_halt || m_halted) m_halted = i_halt;
      else if (m_extra > 0) m_extra--;
      else if (len == 2) m_extra = 1;
    end
    @(negedge i_clk);
  endtask

  initial begin
    clear_inputs();
    i_rst_n = 0;
    step("reset", 1);
    i_rst_n = 1;
    step("idle", 1);

    // Load r5 in EX, ID reads rs=5: one bubble, then normal.
    i_reg_sel_EX = 5; i_flg_mem_rd_EX = 1; i_flg_reg_wr_en_EX = 1;
    i_rs_ID = 5; i_use_rs_ID = 1;
    step("lu_stall", 1);
    i_reg_sel_EX = 0; i_flg_mem_rd_EX = 0; i_flg_reg_wr_en_EX = 0;
    i_reg_sel_MEM = 5; i_flg_mem_rd_MEM = 1;
    step("lu_after", 1);
    check("lu_count", o_stall_cycles, 16'd1);

    // Branch reads rt=7, load r7 in EX: two bubbles.
    clear_inputs();
    i_branch_ID = 1; i_rt_ID = 7; i_use_rt_ID = 1;
    i_reg_sel_EX = 7; i_flg_mem_rd_EX = 1; i_flg_reg_wr_en_EX = 1;
    step("br2_a", 1);
    i_reg_sel_EX = 0; i_flg_mem_rd_EX = 0; i_flg_reg_wr_en_EX = 0;
    i_reg_sel_MEM = 7; i_flg_mem_rd_MEM = 1;
    step("br2_b", 1);
    i_reg_sel_MEM = 0; i_flg_mem_rd_MEM = 0;
    step("br2_run", 1);
    check("br2_count", o_stall_cycles, 16'd3);

    // Branch reads rs=3, ALU writes r3 in EX: one bubble (taken ignored), then flush.
    clear_inputs();
    i_branch_ID = 1; i_rs_ID = 3; i_use_rs_ID = 1;
    i_reg_sel_EX = 3; i_flg_reg_wr_en_EX = 1; i_branch_taken = 1;
    step("br1_stall", 1);
    i_reg_sel_EX = 0; i_flg_reg_wr_en_EX = 0;
    step("br1_flush", 1);
    clear_inputs();
    step("br1_done", 1);

    // Load to r0 never stalls.
    i_reg_sel_EX = 0; i_flg_mem_rd_EX = 1; i_rs_ID = 0; i_use_rs_ID = 1;
    step("r0_load", 1);

    // Halt during the second cycle of a two-cycle stall.
    clear_inputs();
    i_branch_ID = 1; i_rt_ID = 7; i_use_rt_ID = 1;
    i_reg_sel_EX = 7; i_flg_mem_rd_EX = 1;
    step("hlt_first", 1);
    i_reg_sel_EX = 0; i_flg_mem_rd_EX = 0;
    i_halt = 1;
    for (int i = 0; i < 3; i++) step("hlt_on", 1);
    i_halt = 0;
    step("hlt_exit", 1);
    step("hlt_bubble", 1);
    step("hlt_run", 1);
    check("hlt_count", o_stall_cycles, 16'd6);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      i_rst_n            = ($urandom_range(0, 49) != 0);
      i_rs_ID            = 5'($urandom_range(0, 3));
      i_rt_ID            = 5'($urandom_range(0, 3));
      i_use_rs_ID        = 1'($urandom);
      i_use_rt_ID        = 1'($urandom);
      i_branch_ID        = 1'($urandom);
      i_branch_taken     = 1'($urandom);
      i_reg_sel_EX       = 5'($urandom_range(0, 3));
      i_flg_reg_wr_en_EX = 1'($urandom);
      i_flg_mem_rd_EX    = 1'($urandom);
      i_reg_sel_MEM      = 5'($urandom_range(0, 3));
      i_flg_mem_rd_MEM   = 1'($urandom);
      i_halt             = ($urandom_range(0, 7) == 0);
      step("rand", 1);
    end

    // Continuous load-use hazards drive the counter into saturation.
    clear_inputs();
    i_rst_n = 0;
    step("sat_rst", 1);
    i_rst_n = 1;
    i_reg_sel_EX = 1; i_flg_mem_rd_EX = 1; i_rs_ID = 1; i_use_rs_ID = 1;
    for (int n = 0; n < 65540; n++) step("sat", (n > 65530));
    check("sat_hold", o_stall_cycles, 16'hFFFF);

    // Reset in the middle of a two-cycle stall abandons it.
    i_branch_ID = 1;
    step("mid_stall", 1);
    clear_inputs();
    i_rst_n = 0;
    step("mid_rst", 1);
    i_rst_n = 1;
    step("post_rst", 1);
    check("post_rst_cnt", o_stall_cycles, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
